// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions.
//   XLEN           : pc / instruction width
//   NOP_INSTR      : addi x0,x0,0, presented to decode when nothing is valid
//   DISCARD_CYCLES : responses dropped after a flush (imem latency)
//   fetch_entry_t  : one buffered {pc, instr} pair
//   occ_state_t    : queue occupancy class
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int DISCARD_CYCLES = 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;
endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register file for the fetch queue.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : entry to write
//   raddr_i : read index (asynchronous read)
//   rdata_o : entry at raddr_i
// Storage is deliberately not reset; validity is tracked by the owner.
module fq_storage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  fetch_entry_t  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output fetch_entry_t  rdata_o
);
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between imem and the IF/ID register.
//   clk_i, rst_i        : clock (rising), async active-high reset
//   flush_i             : branch|jump flush; empties queue, opens discard window
//   fetch_valid_i/pc/instr, fetch_ready_o : imem response side
//   dec_valid_o/pc/instr, dec_ready_i     : decode side, first-word fall-through
//   count_o             : occupancy
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [XLEN-1:0] fetch_instr_i,
  output logic            fetch_ready_o,
  output logic            dec_valid_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_instr_o,
  input  logic            dec_ready_i,
  output logic [CW-1:0]   count_o
);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          discard_q, discard_d;
  occ_state_t    occ_q, occ_d;
  fetch_entry_t  wr_entry, rd_entry;
  logic          push, pop;

  // Ready is from registered occupancy only: no pass-through when full.
  assign fetch_ready_o = (count_q != CW'(DEPTH));
  assign dec_valid_o   = (occ_q != OCC_EMPTY);

  // Responses arriving in the discard window belong to the flushed path.
  assign push = fetch_valid_i & fetch_ready_o & ~flush_i & ~discard_q;
  assign pop  = dec_valid_o & dec_ready_i & ~flush_i;

  assign wr_entry.pc    = fetch_pc_i;
  assign wr_entry.instr = fetch_instr_i;

  fq_storage #(.DEPTH(DEPTH), .PW(PW)) u_storage (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign dec_pc_o    = dec_valid_o ? rd_entry.pc    : '0;
  assign dec_instr_o = dec_valid_o ? rd_entry.instr : NOP_INSTR;
  assign count_o     = count_q;

  // Pointer / count / discard next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    discard_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      discard_d = (DISCARD_CYCLES != 0);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Occupancy class moves by one step per cycle, or straight to EMPTY on flush.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY:   if (push) occ_d = (DEPTH == 1) ? OCC_FULL : OCC_PARTIAL;
        OCC_PARTIAL: begin
          if (push && !pop && count_q == CW'(DEPTH - 1)) occ_d = OCC_FULL;
          else if (pop && !push && count_q == CW'(1))    occ_d = OCC_EMPTY;
        end
        OCC_FULL:    if (pop) occ_d = (DEPTH == 1) ? OCC_EMPTY : OCC_PARTIAL;
        default:     occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= 1'b0;
      occ_q     <= OCC_EMPTY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      occ_q     <= occ_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            fv = 1'b0;
  logic [31:0]     fpc = '0;
  logic [31:0]     finstr = '0;
  logic            fready;
  logic            dvalid;
  logic [31:0]     dpc;
  logic [31:0]     dinstr;
  logic            dready = 1'b0;
  logic [CW-1:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of {pc,instr} plus "drop the cycle after a flush".
  logic [63:0] mq[$];
  bit          mdrop = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_valid_i(fv), .fetch_pc_i(fpc), .fetch_instr_i(finstr),
    .fetch_ready_o(fready), .dec_valid_o(dvalid), .dec_pc_o(dpc),
    .dec_instr_o(dinstr), .dec_ready_i(dready), .count_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(dvalid), 32'(mq.size() != 0));
    chk({tag, ".ready"}, 32'(fready), 32'(mq.size() < DEPTH));
    chk({tag, ".count"}, 32'(cnt), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk({tag, ".pc"}, dpc, mq[0][63:32]);
      chk({tag, ".instr"}, dinstr, mq[0][31:0]);
    end else begin
      chk({tag, ".pc"}, dpc, 32'h0);
      chk({tag, ".instr"}, dinstr, NOP);
    end
  endtask

  // Called at negedge: drive, check against model, cross one posedge, update model.
  task automatic cycle(input string tag, input bit v, input logic [31:0] pc,
                       input logic [31:0] ins, input bit rdy, input bit fl);
    bit do_push, do_pop;
    fv = v; fpc = pc; finstr = ins; dready = rdy; flush = fl;
    #1;
    chk_model(tag);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mdrop = 1;
    end else begin
      do_push = v && !mdrop && (mq.size() < DEPTH);
      do_pop  = rdy && (mq.size() != 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
      mdrop = 0;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(dvalid), 32'h0);
    chk({tag, ".count"}, 32'(cnt), 32'h0);
    chk({tag, ".instr"}, dinstr, NOP);
    chk({tag, ".pc"}, dpc, 32'h0);
    chk({tag, ".ready"}, 32'(fready), 32'h1);
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  initial begin
    // Power-on reset.
    #1;
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete(); mdrop = 0;

    // Fill past full with decode stalled; third response dropped.
    cycle("t2.p0", 1, 32'h0, ins_of(32'h0), 0, 0);
    cycle("t2.p1", 1, 32'h4, ins_of(32'h4), 0, 0);
    cycle("t2.p2", 1, 32'h8, ins_of(32'h8), 0, 0);
    chk("t2.count_full", 32'(cnt), 32'd2);
    chk("t2.ready_full", 32'(fready), 32'd0);
    chk("t2.head0", dpc, 32'h0);
    cycle("t2.d0", 0, 32'h0, 32'h0, 1, 0);
    chk("t2.head1", dpc, 32'h4);
    cycle("t2.d1", 0, 32'h0, 32'h0, 1, 0);
    chk("t2.empty", 32'(dvalid), 32'd0);

    // Reset mid-run with two entries: outputs clear in the same cycle.
    cycle("t1.p0", 1, 32'h10, ins_of(32'h10), 0, 0);
    cycle("t1.p1", 1, 32'h14, ins_of(32'h14), 0, 0);
    chk("t1.count_pre", 32'(cnt), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_reset("t1.rst");
    mq.delete(); mdrop = 0;
    @(negedge clk);
    rst = 1'b0;

    // Streaming push+pop across pointer wrap: occupancy holds at 1.
    cycle("t3.first", 1, 32'h100, ins_of(32'h100), 1, 0);
    for (int i = 1; i < 8; i++) begin
      chk("t3.count", 32'(cnt), 32'd1);
      chk("t3.pc", dpc, 32'h100 + 32'(4 * (i - 1)));
      cycle("t3.stream", 1, 32'h100 + 32'(4 * i), ins_of(32'h100 + 32'(4 * i)), 1, 0);
    end
    chk("t3.last", dpc, 32'h11C);
    cycle("t3.drain", 0, 32'h0, 32'h0, 1, 0);

    // Flush while full with a concurrent response, then discard window.
    cycle("t4.p0", 1, 32'h30, ins_of(32'h30), 0, 0);
    cycle("t4.p1", 1, 32'h34, ins_of(32'h34), 0, 0);
    cycle("t4.flush", 1, 32'h40, ins_of(32'h40), 1, 1);
    chk("t4.count0", 32'(cnt), 32'd0);
    chk("t4.valid0", 32'(dvalid), 32'd0);
    chk("t4.ready1", 32'(fready), 32'd1);
    cycle("t4.drop", 1, 32'h44, ins_of(32'h44), 0, 0);
    chk("t4.dropped", 32'(cnt), 32'd0);
    cycle("t4.keep", 1, 32'h200, ins_of(32'h200), 0, 0);
    chk("t4.kept_cnt", 32'(cnt), 32'd1);
    chk("t4.kept_pc", dpc, 32'h200);
    cycle("t4.drain", 0, 32'h0, 32'h0, 1, 0);

    // Flush and reset together: reset wins, no discard flag left behind.
    cycle("t5.p0", 1, 32'h60, ins_of(32'h60), 0, 0);
    flush = 1'b1; rst = 1'b1;
    #1;
    chk_reset("t5.rst");
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    mq.delete(); mdrop = 0;
    cycle("t5.first", 1, 32'h0, ins_of(32'h0), 0, 0);
    chk("t5.accepted", 32'(cnt), 32'd1);
    chk("t5.pc", dpc, 32'h0);
    cycle("t5.drain", 0, 32'h0, 32'h0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      cycle("rnd", ($urandom_range(3) != 0), $urandom, $urandom,
            $urandom_range(1) == 1, $urandom_range(15) == 0);
    end
    chk_model("rnd.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
